spi_cmd_ram: RTL and testbench

//  Parametrised command-decoded single-port synchronous RAM behind the SPI slave.

---
 rtl/spi_cmd_ram.sv | 65 ++++++
 tb/tb_spi_cmd_ram.sv | 124 ++++++++++++
 2 files changed

// File: rtl/spi_cmd_ram.sv
// spi_cmd_ram: command-decoded single-port RAM behind the SPI slave with a tx_valid/tx_ack read return.
// Define ADDR_AUTOINC_EN to post-increment wr_addr after WRITE and rd_addr after READ.
module spi_cmd_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              addr_err
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_addr, rd_addr, wr_next, rd_next, addr;
  logic [DATA_W-1:0] payload;
  logic [1:0] cmd;
  logic acc, addr_ok;
  assign cmd      = din[DATA_W+1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign addr     = payload[ADDR_W-1:0];
  assign addr_ok  = {1'b0, addr} < DEPTH;
  assign rx_ready = ~tx_valid | tx_ack;
  assign acc      = rx_valid & rx_ready;
`ifdef ADDR_AUTOINC_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH-1);
  assign wr_next = wr_addr == LAST ? '0 : wr_addr + 1'b1;
  assign rd_next = rd_addr == LAST ? '0 : rd_addr + 1'b1;
`else
  assign wr_next = wr_addr;
  assign rd_next = rd_addr;
`endif
  always_ff @(posedge clk)
    if (rst_n && acc && cmd == 2'b01) mem[wr_addr] <= payload;
  // A READ accepted alongside tx_ack overrides the clear, giving back-to-back reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (tx_valid && tx_ack) tx_valid <= 1'b0;
      if (acc) begin
        if (cmd == 2'b00 || cmd == 2'b10) begin
          if (!addr_ok) addr_err <= 1'b1;
          else if (cmd == 2'b00) wr_addr <= addr;
          else rd_addr <= addr;
        end
        if (cmd == 2'b01) wr_addr <= wr_next;
        if (cmd == 2'b11) begin
          dout     <= mem[rd_addr];
          tx_valid <= 1'b1;
          rd_addr  <= rd_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_ram.sv
// tb_spi_cmd_ram: randomized and directed checks of spi_cmd_ram (depth 200) against a behavioural model.
module tb_spi_cmd_ram;
  localparam int DEPTH = 200;
  logic clk = 0, rst_n = 0, rx_valid = 0, tx_ack = 0;
  logic [9:0] din = '0;
  logic rx_ready, tx_valid, addr_err;
  logic [7:0] dout;
  int total = 0, bad = 0;
  logic [7:0] m_mem [DEPTH];
  int m_wr, m_rd;
  logic [7:0] m_dout;
  logic m_tv, m_err;

  spi_cmd_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dout(dout), .tx_valid(tx_valid), .tx_ack(tx_ack), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(m_tv));
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
    chk({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 0; rx_valid = 0; tx_ack = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_wr = 0; m_rd = 0; m_dout = '0; m_tv = 0; m_err = 0;
    check_out("reset");
    chk("reset.rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // One clock: drive, check rx_ready mid-cycle, advance model, check registered outputs.
  task automatic cyc(input logic v, input logic [1:0] c, input logic [7:0] p, input logic a, input string tag);
    bit acc;
    rx_valid = v; din = {c, p}; tx_ack = a;
    @(negedge clk);
    chk({tag, ".rx_ready"}, 32'(rx_ready), 32'(!m_tv || a));
    acc = v && (!m_tv || a);
    if (m_tv && a) m_tv = 0;
    if (acc)
      case (c)
        2'd0: if (p < DEPTH) m_wr = p; else m_err = 1;
        2'd2: if (p < DEPTH) m_rd = p; else m_err = 1;
        2'd1: begin
          m_mem[m_wr] = p;
`ifdef ADDR_AUTOINC_EN
          m_wr = (m_wr + 1) % DEPTH;
`endif
        end
        default: begin
          m_dout = m_mem[m_rd];
          m_tv = 1;
`ifdef ADDR_AUTOINC_EN
          m_rd = (m_rd + 1) % DEPTH;
`endif
        end
      endcase
    @(posedge clk);
    #1;
    check_out(tag);
    rx_valid = 0; tx_ack = 0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 2'd0, 8'(i), 0, "init.setw");
      cyc(1, 2'd1, 8'($urandom_range(0, 255)), 0, "init.wr");
    end
    cyc(1, 2'd0, 8'h12, 0, "basic.setw");
    cyc(1, 2'd1, 8'hA5, 0, "basic.wr");
    cyc(1, 2'd2, 8'h12, 0, "basic.setr");
    cyc(1, 2'd3, 8'h00, 0, "basic.read");
    chk("basic.dout_a5", 32'(dout), 32'hA5);
    for (int i = 0; i < 5; i++) cyc(0, 2'd0, 8'h00, 0, "bp.hold");
    cyc(1, 2'd1, 8'h5A, 0, "bp.dropped_wr");
    cyc(0, 2'd0, 8'h00, 1, "bp.ack");
    chk("bp.cleared", 32'(tx_valid), 32'd0);
    cyc(1, 2'd2, 8'h12, 0, "bp.setr");
    cyc(1, 2'd3, 8'h00, 0, "bp.reread");
    chk("bp.word_kept", 32'(dout), 32'hA5);
    cyc(1, 2'd2, 8'h40, 1, "b2b.setr");
    cyc(1, 2'd3, 8'h00, 0, "b2b.read1");
    cyc(1, 2'd2, 8'h41, 0, "b2b.setr_blocked");
    cyc(1, 2'd3, 8'h00, 1, "b2b.read2");
    chk("b2b.tv_stays", 32'(tx_valid), 32'd1);
    cyc(0, 2'd0, 8'h00, 1, "b2b.ack");
    cyc(1, 2'd2, 8'h05, 0, "range.setr_ok");
    cyc(1, 2'd2, 8'hC8, 0, "range.setr_bad");
    chk("range.err", 32'(addr_err), 32'd1);
    cyc(1, 2'd3, 8'h00, 0, "range.read_old");
    cyc(0, 2'd0, 8'h00, 1, "range.ack");
    do_reset();
    cyc(1, 2'd0, 8'd198, 0, "inc.setw");
    cyc(1, 2'd1, 8'd1, 0, "inc.wr1");
    cyc(1, 2'd1, 8'd2, 0, "inc.wr2");
    cyc(1, 2'd1, 8'd3, 0, "inc.wr3");
    cyc(1, 2'd2, 8'd198, 0, "inc.setr");
    for (int i = 0; i < 3; i++) cyc(1, 2'd3, 8'h00, 1, "inc.read");
    cyc(0, 2'd0, 8'h00, 1, "inc.ack");
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), "rand");
    cyc(1, 2'd2, 8'h12, 1, "midrst.setr");
    cyc(1, 2'd3, 8'h00, 0, "midrst.read");
    do_reset();
    cyc(1, 2'd2, 8'h12, 0, "midrst.setr2");
    cyc(1, 2'd3, 8'h00, 0, "midrst.mem_kept");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
